// File: rtl/wam_pkg.sv
// Shared constants for the whac-a-mole player-input front end.
// Channel order: switches first, then left, right and pause buttons.
package wam_pkg;

    localparam int WAM_N_SW    = 8;
    localparam int WAM_PRE_DIV = 65536;
    localparam int WAM_DEB_CNT = 8;
    localparam int WAM_REP_DLY = 32;
    localparam int WAM_REP_PER = 8;

    localparam int CH_LFT = WAM_N_SW;
    localparam int CH_RGT = WAM_N_SW + 1;
    localparam int CH_PSE = WAM_N_SW + 2;

    // Re-bases a button channel index onto a non-default switch count.
    function automatic int ch_of(input int base, input int n_sw);
        return base - WAM_N_SW + n_sw;
    endfunction

endpackage

// File: rtl/wam_deb_ch.sv
// One input channel: 2-flop synchronizer, tick-based debounce counter,
// stable level and registered rise/fall pulses gated by armed.
module wam_deb_ch
    import wam_pkg::*;
#(
    parameter int DEB_CNT = WAM_DEB_CNT
) (
    input  logic clk,
    input  logic clr,
    input  logic tick,
    input  logic armed,
    input  logic raw,
    output logic lvl,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEB_CNT + 1);

    logic          s1_q, s2_q;
    logic          stb_q, stb_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stb_d  = stb_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (tick) begin
            if (s2_q != stb_q) begin
                if (cnt_q == CW'(DEB_CNT - 1)) begin
                    stb_d  = s2_q;
                    cnt_d  = '0;
                    rise_d = armed & s2_q;
                    fall_d = armed & ~s2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            stb_q  <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            stb_q  <= stb_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign lvl  = stb_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/wam_inp.sv
// Player-input front end: prescaler, arming, per-channel debounce, pause toggle.
// Define WAM_INP_REPEAT_EN to add auto-repeat on the left/right buttons.
module wam_inp
    import wam_pkg::*;
#(
    parameter int N_SW    = WAM_N_SW,
    parameter int PRE_DIV = WAM_PRE_DIV,
    parameter int DEB_CNT = WAM_DEB_CNT
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [N_SW-1:0] sw,
    input  logic            lft,
    input  logic            rgt,
    input  logic            pse,
    output logic [N_SW-1:0] sw_lvl,
    output logic [N_SW-1:0] tap,
    output logic            lft_p,
    output logic            rgt_p,
    output logic            pse_flg
);

    localparam int NCH = N_SW + 3;
    localparam int PW  = $clog2(PRE_DIV);
    localparam int AW  = $clog2(DEB_CNT + 2);
    localparam int LFT = ch_of(CH_LFT, N_SW);
    localparam int RGT = ch_of(CH_RGT, N_SW);
    localparam int PSE = ch_of(CH_PSE, N_SW);

    logic [PW-1:0]  pre_q, pre_d;
    logic [AW-1:0]  arm_q, arm_d;
    logic           armed_q, armed_d;
    logic           pse_q, pse_d;
    logic           tick;
    logic [NCH-1:0] raw, lvl, rise, fall;

    assign raw  = {pse, rgt, lft, sw};
    assign tick = (pre_q == PW'(PRE_DIV - 1));

    // armed rises one tick after DEB_CNT+1 ticks, so power-on levels settle silently
    always_comb begin
        pre_d   = tick ? '0 : pre_q + 1'b1;
        arm_d   = arm_q;
        armed_d = armed_q;
        if (tick) begin
            if (arm_q == AW'(DEB_CNT + 1))
                armed_d = 1'b1;
            else
                arm_d = arm_q + 1'b1;
        end
        pse_d = pse_q ^ rise[PSE];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pre_q   <= '0;
            arm_q   <= '0;
            armed_q <= 1'b0;
            pse_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            arm_q   <= arm_d;
            armed_q <= armed_d;
            pse_q   <= pse_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        wam_deb_ch #(
            .DEB_CNT(DEB_CNT)
        ) u_ch (
            .clk  (clk),
            .clr  (clr),
            .tick (tick),
            .armed(armed_q),
            .raw  (raw[i]),
            .lvl  (lvl[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign sw_lvl  = lvl[N_SW-1:0];
    assign tap     = rise[N_SW-1:0] | fall[N_SW-1:0];
    assign pse_flg = pse_q;

`ifdef WAM_INP_REPEAT_EN
    localparam int RW = $clog2(WAM_REP_DLY + 1);

    logic [1:0]         hold;
    logic [1:0]         rp_q, rp_d;
    logic [1:0][RW-1:0] rep_q, rep_d;

    assign hold = {lvl[RGT], lvl[LFT]};

    // after the first repeat the counter reloads so later repeats come every REP_PER ticks
    always_comb begin
        rep_d = rep_q;
        rp_d  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (!hold[i]) begin
                rep_d[i] = '0;
            end else if (tick) begin
                if (rep_q[i] == RW'(WAM_REP_DLY - 1)) begin
                    rep_d[i] = RW'(WAM_REP_DLY - WAM_REP_PER);
                    rp_d[i]  = armed_q;
                end else begin
                    rep_d[i] = rep_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rep_q <= '0;
            rp_q  <= 2'b00;
        end else begin
            rep_q <= rep_d;
            rp_q  <= rp_d;
        end
    end

    assign lft_p = rise[LFT] | rp_q[0];
    assign rgt_p = rise[RGT] | rp_q[1];
`else
    assign lft_p = rise[LFT];
    assign rgt_p = rise[RGT];
`endif

    logic unused_btn;
    assign unused_btn = ^{fall[NCH-1:N_SW], lvl[NCH-1:N_SW]};

endmodule

// File: tb/tb_wam_inp.sv
// Scoreboard bench for wam_inp with PRE_DIV=4, DEB_CNT=3.
// Expected pulse events are queued at stimulus time and popped by a monitor.
module tb_wam_inp;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] sw  = 8'h00;
    logic       lft = 1'b0;
    logic       rgt = 1'b0;
    logic       pse = 1'b0;
    logic [7:0] sw_lvl;
    logic [7:0] tap;
    logic       lft_p;
    logic       rgt_p;
    logic       pse_flg;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [7:0] tap;
        logic       l;
        logic       r;
    } ev_t;

    ev_t exp_q[$];

    wam_inp #(
        .N_SW   (8),
        .PRE_DIV(4),
        .DEB_CNT(3)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .sw     (sw),
        .lft    (lft),
        .rgt    (rgt),
        .pse    (pse),
        .sw_lvl (sw_lvl),
        .tap    (tap),
        .lft_p  (lft_p),
        .rgt_p  (rgt_p),
        .pse_flg(pse_flg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) begin
        if (clr) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        ev_t e;
        if (!clr && (tap != 8'h00 || lft_p || rgt_p)) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event got tap=%h l=%b r=%b required none",
                         tap, lft_p, rgt_p);
            end else begin
                e = exp_q.pop_front();
                if ({tap, lft_p, rgt_p} !== e) begin
                    n_fail++;
                    $display("FAIL event got tap=%h l=%b r=%b required tap=%h l=%b r=%b",
                             tap, lft_p, rgt_p, e.tap, e.l, e.r);
                end
            end
        end
    end

    task automatic wait_lvl(input int b, input logic v, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sw_lvl[b] !== v && n < 40);
    endtask

    task automatic test_reset;
        clr = 1'b1;
        sw  = 8'h05;
        repeat (3) @(negedge clk);
        n_chk++;
        if (sw_lvl !== 8'h00 || tap !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out got lvl=%h tap=%h required 00 00", sw_lvl, tap);
        end
        n_chk++;
        if (pse_flg !== 1'b0 || lft_p !== 1'b0 || rgt_p !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_btn got p=%b l=%b r=%b required 0", pse_flg, lft_p, rgt_p);
        end
        clr = 1'b0;
        repeat (20) @(negedge clk);
        n_chk++;
        if (sw_lvl !== 8'h05) begin
            n_fail++;
            $display("FAIL poweron_lvl got %h required 05", sw_lvl);
        end
        repeat (10) @(negedge clk);
        n_chk++;
        if (pse_flg !== 1'b0) begin
            n_fail++;
            $display("FAIL poweron_pse got %b required 0", pse_flg);
        end
    endtask

    task automatic test_clean_edge;
        int n;
        exp_q.push_back('{tap: 8'h01, l: 1'b0, r: 1'b0});
        sw[0] = 1'b0;
        wait_lvl(0, 1'b0, n);
        n_chk++;
        if (sw_lvl !== 8'h04) begin
            n_fail++;
            $display("FAIL drop0_lvl got %h required 04", sw_lvl);
        end
        repeat (8) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{tap: 8'h08, l: 1'b0, r: 1'b0});
            sw[3] = (k == 0);
            wait_lvl(3, (k == 0), n);
            n_chk++;
            if (sw_lvl[3] !== (k == 0) || n < 10 || n > 18) begin
                n_fail++;
                $display("FAIL sw3_edge%0d got lvl=%b after %0d clk required %b in 10..18",
                         k, sw_lvl[3], n, (k == 0));
            end
            n_chk++;
            if (tap !== 8'h08) begin
                n_fail++;
                $display("FAIL sw3_tap%0d got %h required 08", k, tap);
            end
            @(negedge clk);
            n_chk++;
            if (tap !== 8'h00) begin
                n_fail++;
                $display("FAIL sw3_width%0d got %h required 00", k, tap);
            end
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic test_bounce;
        int n;
        sw[0] = 1'b1;
        repeat (4) @(negedge clk);
        sw[0] = 1'b0;
        repeat (4) @(negedge clk);
        n_chk++;
        if (sw_lvl[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_hold got %b required 0", sw_lvl[0]);
        end
        exp_q.push_back('{tap: 8'h01, l: 1'b0, r: 1'b0});
        sw[0] = 1'b1;
        wait_lvl(0, 1'b1, n);
        n_chk++;
        if (sw_lvl !== 8'h05 || n < 10 || n > 18) begin
            n_fail++;
            $display("FAIL bounce_settle got lvl=%h after %0d clk required 05 in 10..18",
                     sw_lvl, n);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_pause;
        logic model = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pse = 1'b1;
            model = ~model;
            repeat (24) @(negedge clk);
            n_chk++;
            if (pse_flg !== model) begin
                n_fail++;
                $display("FAIL pse_press%0d got %b required %b", k, pse_flg, model);
            end
            pse = 1'b0;
            repeat (24) @(negedge clk);
            n_chk++;
            if (pse_flg !== model) begin
                n_fail++;
                $display("FAIL pse_release%0d got %b required %b", k, pse_flg, model);
            end
        end
    endtask

    task automatic test_lr_together;
        exp_q.push_back('{tap: 8'h00, l: 1'b1, r: 1'b1});
        lft = 1'b1;
        rgt = 1'b1;
        repeat (24) @(negedge clk);
        lft = 1'b0;
        rgt = 1'b0;
        repeat (24) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL lr_pending got %0d events required 0", exp_q.size());
        end
    endtask

    task automatic test_clr_mid;
        int g = 0;
        while ((cyc % 4) != 0 && g < 8) begin
            @(negedge clk);
            g++;
        end
        sw[5] = 1'b1;
        repeat (8) @(negedge clk);
        n_chk++;
        if (sw_lvl[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_lvl got %b required 0", sw_lvl[5]);
        end
        clr = 1'b1;
        #1;
        n_chk++;
        if ({sw_lvl, tap, lft_p, rgt_p, pse_flg} !== 19'h0) begin
            n_fail++;
            $display("FAIL async_clr got lvl=%h tap=%h l=%b r=%b p=%b required 0",
                     sw_lvl, tap, lft_p, rgt_p, pse_flg);
        end
        @(negedge clk);
        clr = 1'b0;
        repeat (40) @(negedge clk);
        n_chk++;
        if (sw_lvl !== 8'h25 || pse_flg !== 1'b0) begin
            n_fail++;
            $display("FAIL reclr_lvl got lvl=%h p=%b required 25 0", sw_lvl, pse_flg);
        end
    endtask

    task automatic test_repeat;
        int t[$];
        int exp_n;
`ifdef WAM_INP_REPEAT_EN
        exp_n = 5;
`else
        exp_n = 1;
`endif
        for (int k = 0; k < exp_n; k++)
            exp_q.push_back('{tap: 8'h00, l: 1'b1, r: 1'b0});
        lft = 1'b1;
        for (int i = 0; i < 284; i++) begin
            @(negedge clk);
            if (lft_p === 1'b1) t.push_back(i);
            if (i == 243) lft = 1'b0;
        end
        n_chk++;
        if (t.size() != exp_n) begin
            n_fail++;
            $display("FAIL rep_count got %0d required %0d", t.size(), exp_n);
        end
`ifdef WAM_INP_REPEAT_EN
        if (t.size() == 5) begin
            n_chk++;
            if (t[1] - t[0] != 128 || t[2] - t[1] != 32 ||
                t[3] - t[2] != 32 || t[4] - t[3] != 32) begin
                n_fail++;
                $display("FAIL rep_gap got %0d %0d %0d %0d required 128 32 32 32",
                         t[1] - t[0], t[2] - t[1], t[3] - t[2], t[4] - t[3]);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_clean_edge();
        test_bounce();
        test_pause();
        test_lr_together();
        test_clr_mid();
        test_repeat();
        repeat (4) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wam_inp.md
Name: wam_inp

Overview:
- Player-input front end of the whac-a-mole game; the producer side of the tap, difficulty and pause signals that the game core consumes.
- Synchronizes and debounces the 8 mole switches and the 3 buttons (left, right, pause).
- Emits single-cycle tap pulses on any debounced switch transition, single-cycle left/right press pulses, and a pause level that toggles on each press.
- Sits between the board pins and the game core (mole hit logic, hardness control, clock gating).

Parameters:
- N_SW, 8, number of switch channels.
- PRE_DIV, 65536, clk cycles per sample tick (>=2).
- DEB_CNT, 8, consecutive disagreeing ticks needed to accept a new level (>=1).

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous, active-high reset.
- sw  in  N_SW  raw slide switches, asynchronous.
- lft  in  1  raw left button, asynchronous.
- rgt  in  1  raw right button, asynchronous.
- pse  in  1  raw pause button, asynchronous.
- sw_lvl  out  N_SW  debounced switch levels.
- tap  out  N_SW  one-cycle pulse per debounced switch transition, either direction.
- lft_p  out  1  one-cycle pulse on debounced left press (0->1).
- rgt_p  out  1  one-cycle pulse on debounced right press (0->1).
- pse_flg  out  1  pause state; toggles on each debounced pause press.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (clr). While clr=1, every output is 0, all synchronizers, counters and prescaler are 0, and armed=0.
- Synchronizer: two flops per raw input (N_SW+3 channels).
- Prescaler: counts 0..PRE_DIV-1 and wraps to 0. tick=1 for exactly one clk when the count equals PRE_DIV-1.
- Per-channel debounce, on each tick:
  - sync != stable: cnt++. When cnt reaches DEB_CNT, stable<=sync and cnt<=0.
  - sync == stable: cnt<=0. Any bounce back restarts the count.
- cnt is clog2(DEB_CNT+1) bits wide and never wraps.
- Latency: a clean edge appears on stable 2 clk + DEB_CNT ticks later. Jitter is up to one PRE_DIV period.
- Edge pulses: tap[i], lft_p, rgt_p and pse_flg update are registered. They assert in the same cycle the stable value first shows the new level, for exactly one clk.
- Button releases (1->0) produce no pulse. Switch transitions in both directions produce tap.
- Arming:
  - armed is set on the tick after DEB_CNT+1 ticks have elapsed since reset release.
  - Until armed, stable values track inputs normally, but tap, lft_p, rgt_p and pse toggling are suppressed.
  - Effect: switches already up at power-on raise no spurious taps.
- Simultaneous events: channels are fully independent. Several tap bits may assert in the same cycle. lft_p and rgt_p together are both emitted.
- clr asserted mid-debounce aborts it. After release, the channel re-debounces from stable=0.
- pse_flg is a plain toggle flop. It does not gate any clock internally.

Optional Feature:
- Macro: WAM_INP_REPEAT_EN.
- Defined:
  - lft and rgt auto-repeat. While a button's stable level stays 1, a repeat counter counts ticks.
  - First repeat pulse comes at 32 ticks after the press pulse, then one every 8 ticks.
  - Release or clr clears the repeat counter. Repeats are suppressed when armed=0.
- Undefined: exactly one pulse per press. No repeat counters are synthesized.

Decomposition:
- Shared package wam_pkg:
  - WAM_N_SW=8.
  - Default PRE_DIV and DEB_CNT.
  - WAM_REP_DLY=32 and WAM_REP_PER=8.
  - Channel index constants (CH_LFT=N_SW, CH_RGT=N_SW+1, CH_PSE=N_SW+2).
- One sub-module, wam_deb_ch: one channel containing synchronizer, counter, stable flop and edge detect.
  - Inputs: clk, clr, tick, armed, raw.
  - Outputs: lvl, rise, fall.
  - Instantiated N_SW+3 times. The top holds the prescaler, armed logic, toggle and the optional repeat.

Test Plan (bench uses PRE_DIV=4, DEB_CNT=3):
- Reset with sw=8'h05 held, release clr -> sw_lvl=8'h05 after ~14 clk, tap stays 8'h00 throughout, pse_flg=0.
- After arming, sw[3] 0->1 clean -> sw_lvl[3]=1 and tap=8'h08 for exactly 1 clk, 2+3 ticks (+≤4 clk) later. Then 1->0 -> tap=8'h08 again.
- sw[0] bounces 0->1->0->1 with each level held 1 tick -> no tap until the level holds 3 ticks, then exactly one tap=8'h01.
- Three pse presses, each 6 ticks long -> pse_flg goes 1,0,1. Releases cause no change. lft and rgt pressed together -> lft_p and rgt_p pulse in the same cycle.
- clr pulsed while sw[5] is mid-debounce (cnt=2) -> all outputs 0 immediately (asynchronous); after release, sw[5] re-debounces from 0 with no tap until armed.
- With WAM_INP_REPEAT_EN: hold lft 60 ticks -> lft_p at press, then at +32, +40, +48, +56 ticks (5 pulses). Without the macro -> 1 pulse.
